alu_iter_divider: RTL and testbench
===================================

Name: alu_iter_divider

Overview:
Multi-cycle restoring divider for the 8-bit core ALU.
- Produces quotient and remainder that feed dedicated data inputs of the ALU result-select multiplexer.
- The multiplexer picks them up when the DIV/MOD opcodes are selected.
- The sequencer starts it with a one-cycle pulse. It stalls on busy and samples results on the done pulse.

Parameters:
N, 8, operand/result width in bits (N >= 2)
CW, $clog2(N+1), iteration counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; accepted only in IDLE
is_signed  in  1  signed-mode select; sampled with start
dividend  in  N  numerator; sampled with start
divisor  in  N  denominator; sampled with start
busy  out  1  high while a division is in progress
done  out  1  one-cycle pulse when results update
quotient  out  N  registered quotient; holds until next done
remainder  out  N  registered remainder; holds until next done
div_zero  out  1  registered; set when the last completed op had divisor == 0

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_zero=0, counter=0, internal partial remainder and shift registers all 0.
- FSM states: IDLE, RUN, FIN.
- IDLE, start=1, divisor != 0:
  - Latch operands.
  - Clear the partial remainder.
  - Counter = N.
  - Next state RUN; busy=1 from the next cycle.
- IDLE, start=1, divisor == 0:
  - Next state FIN immediately; no iterations.
  - Results: quotient = all ones, remainder = dividend, div_zero=1.
- RUN, one restoring step per cycle:
  - Shift {rem, dvd} left by 1.
  - Trial = rem - divisor, computed at N+1 bits.
  - If trial is non-negative: rem = trial, shift in 1. Otherwise keep rem, shift in 0.
  - Counter decrements. When the counter reaches 1 in RUN, next state is FIN.
- FIN:
  - Write quotient, remainder and div_zero registers.
  - done=1 and busy=0 for exactly this cycle.
  - Next state IDLE.
- Latency: start accepted in cycle 0 -> done in cycle N+1 (cycle 9 for N=8). Divide-by-zero: done in cycle 1.
- Back-to-back: start asserted during the FIN cycle is ignored. The next accepted start is in the following IDLE cycle.
- start while busy: ignored; latched operands and outputs are unaffected.
- Operand changes after the start cycle have no effect.
- Outputs change only on a done cycle or on reset.
- Reset mid-operation: immediate return to IDLE with all outputs cleared; no done pulse is produced.
- Arithmetic in unsigned mode:
  - All values unsigned N-bit.
  - Results satisfy dividend = quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
Macro ALU_SIGNED_DIV_EN.
- Defined:
  - When is_signed=1 at start, operands are converted to magnitude, divided unsigned, then fixed up in FIN.
  - Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend (truncating division).
  - Overflow case: most-negative / -1 gives quotient = most-negative (0x80), remainder=0, div_zero=0.
  - Divide-by-zero gives the same result as unsigned: quotient all ones, remainder=dividend.
  - The sign fix-up is done in FIN; latency is unchanged.
- Undefined:
  - is_signed is ignored and all divisions are unsigned.
  - The port remains present for interface stability.

Test Plan:
- Reset, then start with 200/7 unsigned -> busy cycles 1-8; done pulse in cycle 9 with quotient=28 (0x1C), remainder=4, div_zero=0; values held afterwards.
- Start 5/0 -> done in cycle 1 with quotient=0xFF, remainder=5, div_zero=1. Then 255/1 -> quotient=0xFF, remainder=0, div_zero=0.
- Start 100/10, then pulse start with 9/3 in cycles 3 and 9 (FIN) -> second request ignored both times; result is quotient=10, remainder=0; the following IDLE start of 9/3 gives quotient=3 in its cycle 9.
- Start 0xFF/0x10, then assert rst_n=0 in cycle 4 -> busy=0 and all outputs 0 immediately; no done pulse; the next start completes normally.
- With ALU_SIGNED_DIV_EN, is_signed=1:
  - -7/2 -> quotient=0xFD, remainder=0xFF.
  - 7/-2 -> quotient=0xFD, remainder=0x01.
  - -128/-1 -> quotient=0x80, remainder=0x00.
- Without ALU_SIGNED_DIV_EN, is_signed=1 with 0xF9/0x02 -> quotient=0x7C, remainder=0x01 (unsigned result).

Source files
------------

// File: rtl/alu_iter_divider.sv
// ---------------------------------------------------------------------------
// alu_iter_divider
//
// Multi-cycle restoring divider for the core ALU. It produces a quotient and
// a remainder for the DIV/MOD inputs of the ALU result-select multiplexer.
// The sequencer starts an operation with a one-cycle start pulse. It stalls
// while busy is high and samples the results on the one-cycle done pulse.
//
// Timing: a start accepted in cycle 0 gives done in cycle N+1. A divide by
// zero skips the iterations and gives done in cycle 1.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle request, accepted only in IDLE
//   is_signed  signed-mode select, sampled with start
//   dividend   numerator, sampled with start
//   divisor    denominator, sampled with start
//   busy       high while the iterations are in progress
//   done       one-cycle pulse in the cycle the result registers update
//   quotient   registered quotient, held until the next done
//   remainder  registered remainder, held until the next done
//   div_zero   registered flag, set when the last op had divisor == 0
//
// Optional feature: define ALU_SIGNED_DIV_EN to enable truncating signed
// division when is_signed is high. Without the macro, is_signed is ignored
// and every division is unsigned. The port stays in place in both builds.
// ---------------------------------------------------------------------------
module alu_iter_divider #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         is_signed,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Control strobes decoded by the FSM.
    logic load;         // accept operands and begin iterating
    logic step;         // perform one restoring step
    logic commit;       // last step: write the fixed-up results
    logic zero_commit;  // divide by zero: write the fixed results

    // Iteration datapath registers.
    logic [N-1:0]  rem_q;      // partial remainder
    logic [N-1:0]  dvd_q;      // dividend bits shifting out, quotient bits shifting in
    logic [N-1:0]  dsr_q;      // divisor magnitude
    logic [CW-1:0] cnt_q;      // remaining iterations
    logic          neg_quo_q;  // negate the quotient at commit
    logic          neg_rem_q;  // negate the remainder at commit

    // ------------------------------------------------------------------
    // Signed-mode operand conditioning
    // ------------------------------------------------------------------
    logic signed_op;

`ifdef ALU_SIGNED_DIV_EN
    assign signed_op = is_signed;
`else
    // The port is still read here, so the unsigned build has no dangling
    // input. The constant zero removes all of the sign logic below.
    assign signed_op = 1'b0 & is_signed;
`endif

    logic         dvd_neg, dsr_neg;
    logic [N-1:0] dvd_mag, dsr_mag;

    assign dvd_neg = signed_op & dividend[N-1];
    assign dsr_neg = signed_op & divisor[N-1];
    // The most-negative value maps to itself. Read as an unsigned magnitude,
    // that is the correct value, so MIN / -1 needs no special case.
    assign dvd_mag = dvd_neg ? (~dividend + N'(1)) : dividend;
    assign dsr_mag = dsr_neg ? (~divisor  + N'(1)) : divisor;

    // ------------------------------------------------------------------
    // One restoring step
    // ------------------------------------------------------------------
    logic [N:0]   rem_sh;
    logic [N:0]   trial;
    logic [N-1:0] rem_step;
    logic [N-1:0] quo_step;
    logic [N-1:0] quo_fix;
    logic [N-1:0] rem_fix;

    // The partial remainder is always below the divisor. The shifted value
    // is therefore below 2*divisor, and an (N+1)-bit trial never overflows.
    // The trial's MSB is its sign.
    assign rem_sh   = {rem_q, dvd_q[N-1]};
    assign trial    = rem_sh - {1'b0, dsr_q};
    assign rem_step = trial[N] ? rem_sh[N-1:0] : trial[N-1:0];
    assign quo_step = {dvd_q[N-2:0], ~trial[N]};

    // The sign fix-up is applied as the results are written. This keeps the
    // registers valid in the same cycle as the done pulse.
    assign quo_fix = neg_quo_q ? (~quo_step + N'(1)) : quo_step;
    assign rem_fix = neg_rem_q ? (~rem_step + N'(1)) : rem_step;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments, so every
            // register samples the values from before the edge.
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default first. Without it, a path that
        // skips an assignment infers a latch.
        state_nxt   = state;
        busy        = 1'b0;
        done        = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        commit      = 1'b0;
        zero_commit = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        zero_commit = 1'b1;
                        state_nxt   = FIN;
                    end else begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_q == CW'(1)) begin
                    commit    = 1'b1;
                    state_nxt = FIN;
                end
            end
            FIN: begin
                // A start seen here is dropped. The next request is taken
                // in the following IDLE cycle.
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            if (load) begin
                rem_q     <= '0;
                dvd_q     <= dvd_mag;
                dsr_q     <= dsr_mag;
                cnt_q     <= CW'(N);
                neg_quo_q <= dvd_neg ^ dsr_neg;
                neg_rem_q <= dvd_neg;
            end

            if (step) begin
                rem_q <= rem_step;
                dvd_q <= quo_step;
                cnt_q <= cnt_q - CW'(1);
            end

            if (commit) begin
                quotient  <= quo_fix;
                remainder <= rem_fix;
                div_zero  <= 1'b0;
            end

            if (zero_commit) begin
                quotient  <= '1;
                remainder <= dividend;
                div_zero  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_iter_divider.sv
// ---------------------------------------------------------------------------
// tb_alu_iter_divider
//
// Self-checking bench for alu_iter_divider (N = 8). Each accepted request
// pushes its expected result onto a scoreboard queue. The entry is popped
// and compared when done is seen. Define ALU_SIGNED_DIV_EN for both the
// bench and the design to run the signed cases.
// ---------------------------------------------------------------------------
module tb_alu_iter_divider;

    localparam int N = 8;

`ifdef ALU_SIGNED_DIV_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;

    int   vectors;
    int   miscompares;
    exp_t sb[$];

    // Result values the bench expects the DUT to be holding.
    logic [N-1:0] hold_q;
    logic [N-1:0] hold_r;
    logic         hold_dz;

    alu_iter_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: truncating division with the divide-by-zero and
    // overflow conventions of the divider.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sgn);
        exp_t e;
        int   sa;
        int   sd;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else if (sgn && SIGNED_EN) begin
            sa   = $signed(a);
            sd   = $signed(b);
            e.dz = 1'b0;
            if (sa == -128 && sd == -1) begin
                e.q = 8'h80;
                e.r = 8'h00;
            end else begin
                e.q = 8'(sa / sd);
                e.r = 8'(sa % sd);
            end
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Run one operation from an IDLE cycle. With inject set, a 9/3 start is
    // also pulsed in cycle 3 and in the done cycle, and both must be ignored.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic sgn, input bit inject);
        exp_t e;
        int   lat;
        int   cyc;
        bit   seen;
        lat = (b == '0) ? 1 : N + 1;
        sb.push_back(model(a, b, sgn));
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        seen      = 1'b0;
        cyc       = 0;
        while (!seen && cyc < N + 4) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                // Operand changes after the start cycle must have no effect.
                start     = 1'b0;
                dividend  = 8'($urandom);
                divisor   = 8'($urandom);
                is_signed = 1'($urandom);
            end
            if (inject && cyc == 3) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd3;
            end
            if (inject && cyc == 4) start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                check("busy_during_run", busy, 1'b1);
                check("quotient_held", quotient, hold_q);
                check("remainder_held", remainder, hold_r);
            end
        end
        check("done_seen", seen, 1'b1);
        check("latency", cyc, lat);
        check("busy_in_fin", busy, 1'b0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_zero", div_zero, e.dz);
            hold_q  = e.q;
            hold_r  = e.r;
            hold_dz = e.dz;
        end
        if (inject) begin
            start    = 1'b1;
            dividend = 8'd9;
            divisor  = 8'd3;
        end
        tick();
        start = 1'b0;
        check("done_one_cycle", done, 1'b0);
        check("busy_after_fin", busy, 1'b0);
        check("quotient_after_fin", quotient, hold_q);
    endtask

    initial begin
        int done_count;
        vectors     = 0;
        miscompares = 0;
        hold_q      = '0;
        hold_r      = '0;
        hold_dz     = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b0;
        is_signed   = 1'b0;
        dividend    = '0;
        divisor     = '0;

        // Reset state.
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_quotient", quotient, 8'h00);
        check("rst_remainder", remainder, 8'h00);
        check("rst_div_zero", div_zero, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // 200 / 7 unsigned.
        do_op(8'd200, 8'd7, 1'b0, 1'b0);
        check("c200_7_q", quotient, 8'h1C);
        check("c200_7_r", remainder, 8'h04);

        // Divide by zero, then the largest quotient without div_zero.
        do_op(8'd5, 8'd0, 1'b0, 1'b0);
        check("c5_0_q", quotient, 8'hFF);
        check("c5_0_dz", div_zero, 1'b1);
        do_op(8'd255, 8'd1, 1'b0, 1'b0);
        check("c255_1_dz", div_zero, 1'b0);

        // Starts while busy and during FIN are ignored. Then 9/3 runs.
        do_op(8'd100, 8'd10, 1'b0, 1'b1);
        check("c100_10_q", hold_q, 8'd10);
        do_op(8'd9, 8'd3, 1'b0, 1'b0);
        check("c9_3_q", quotient, 8'd3);

        // Reset in the middle of an operation.
        dividend = 8'hFF;
        divisor  = 8'h10;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_quotient", quotient, 8'h00);
        check("midrst_remainder", remainder, 8'h00);
        check("midrst_div_zero", div_zero, 1'b0);
        hold_q  = '0;
        hold_r  = '0;
        hold_dz = 1'b0;
        tick();
        rst_n      = 1'b1;
        done_count = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) done_count++;
        end
        check("midrst_no_done", done_count, 0);
        do_op(8'hFF, 8'h10, 1'b0, 1'b0);

        // is_signed set: a signed result with the macro, unsigned without it.
        if (SIGNED_EN) begin
            do_op(8'hF9, 8'h02, 1'b1, 1'b0);
            check("s_m7_2_q", quotient, 8'hFD);
            check("s_m7_2_r", remainder, 8'hFF);
            do_op(8'h07, 8'hFE, 1'b1, 1'b0);
            check("s_7_m2_q", quotient, 8'hFD);
            check("s_7_m2_r", remainder, 8'h01);
            do_op(8'h80, 8'hFF, 1'b1, 1'b0);
            check("s_ovf_q", quotient, 8'h80);
            check("s_ovf_r", remainder, 8'h00);
            do_op(8'h83, 8'h00, 1'b1, 1'b0);
        end else begin
            do_op(8'hF9, 8'h02, 1'b1, 1'b0);
            check("u_f9_2_q", quotient, 8'h7C);
            check("u_f9_2_r", remainder, 8'h01);
        end

        // Random mix, occasionally with a zero divisor.
        for (int i = 0; i < 10; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            do_op(ra, rb, 1'($urandom), 1'b0);
        end

        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
